// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_pkg
// Purpose  : Shared constants, FSM state type and word-address helper for the
//            instruction-cache line-fill responder.
// Ports    : (package - none)
// Revision : 1.0  initial release
// ============================================================================
package icache_pkg;

  localparam int LINE_BYTES = 64;
  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = LINE_BYTES / (WORD_W / 8);
  localparam int OFFSET_W   = $clog2(LINE_BYTES);
  localparam int TAG_W      = 32 - OFFSET_W;
  localparam int IDX_W      = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Byte address of word 'idx' within the line whose base is 'base'.
  function automatic logic [31:0] line_word_addr(input logic [TAG_W-1:0] base,
                                                 input logic [IDX_W-1:0] idx);
    return {base, idx, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_fill_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : icache_line_fill_line_buf
// Purpose  : One-line return buffer: 16 x 32-bit word array plus tag/valid.
// Ports    : clk, rst_n          clock, async active-low reset
//            wr_en_i/idx/data    single-word write port into the line
//            set_i, tag_i        record the tag and mark the line valid
//            clr_i               invalidate (wins over set_i)
//            cmp_tag_i, match_o  valid && tag == cmp_tag_i
//            tag_o, line_o       stored tag and flattened line (word 0 low)
// Revision : 1.0  initial release
// ============================================================================
module icache_line_fill_line_buf
  import icache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en_i,
  input  logic [IDX_W-1:0]             wr_idx_i,
  input  logic [WORD_W-1:0]            wr_data_i,
  input  logic                         set_i,
  input  logic [TAG_W-1:0]             tag_i,
  input  logic                         clr_i,
  input  logic [TAG_W-1:0]             cmp_tag_i,
  output logic                         match_o,
  output logic [TAG_W-1:0]             tag_o,
  output logic [LINE_WORDS*WORD_W-1:0] line_o
);

  logic [WORD_W-1:0] words_q [LINE_WORDS];
  logic [TAG_W-1:0]  tag_q;
  logic              valid_q;

  // Line data is a don't-care until a fill has written it, so it has no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      words_q[wr_idx_i] <= wr_data_i;
    end
  end

  // The tag is written even when clr_i suppresses valid, so a line filled in
  // the same cycle as an invalidate can still be matched for its own response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (set_i) begin
        tag_q <= tag_i;
      end
      if (clr_i) begin
        valid_q <= 1'b0;
      end else if (set_i) begin
        valid_q <= 1'b1;
      end
    end
  end

  assign match_o = valid_q && (tag_q == cmp_tag_i);
  assign tag_o   = tag_q;

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_flat
    assign line_o[gi*WORD_W +: WORD_W] = words_q[gi];
  end

endmodule
`default_nettype wire

// File: rtl/icache_line_fill.sv
`default_nettype none
// ============================================================================
// Module   : icache_line_fill
// Purpose  : Memory-side responder for instruction-cache line fills. Fetches
//            the 64-byte line around a miss address as 16 word reads, returns
//            it with a one-cycle ready pulse and keeps it for repeat requests.
// Ports    : clk, rst_n             clock, async active-low reset
//            req_valid, req_addr    miss request (held until served)
//            resp_ready, resp_data  one-cycle line return, word 0 low
//            bus_req/addr/ack/rdata/err  32-bit backing-bus read port
//            fill_err               one-cycle pulse when a fetch is abandoned
//            buf_inv                invalidate the return buffer
// Revision : 1.0  initial release
// ============================================================================
module icache_line_fill #(
  parameter int LINE_WORDS = 16,   // only 16 is supported
  parameter bit BUF_EN     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic [31:0]             req_addr,
  output logic                    resp_ready,
  output logic [32*LINE_WORDS-1:0] resp_data,
  output logic                    bus_req,
  output logic [31:0]             bus_addr,
  input  logic                    bus_ack,
  input  logic [31:0]             bus_rdata,
  input  logic                    bus_err,
  output logic                    fill_err,
  input  logic                    buf_inv
);

  import icache_pkg::*;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] beat_q,  beat_d;
  logic [TAG_W-1:0] base_q,  base_d;
  logic             done_q,  done_d;   // all beats received, handing off to RESP
  logic             cool_q,  cool_d;   // first IDLE cycle after RESP

  logic [TAG_W-1:0] w_req_tag;
  logic [TAG_W-1:0] w_buf_tag;
  logic             w_buf_match;
  logic             w_hit_ok;
  logic             w_wr_en;
  logic             w_set;
  logic             w_clr;
  logic             w_unused;

  assign w_req_tag = req_addr[31:OFFSET_W];
  assign w_unused  = ^req_addr[OFFSET_W-1:0];

  if (BUF_EN) begin : g_buf_on
    assign w_hit_ok = w_buf_match;
  end else begin : g_buf_off
    assign w_hit_ok = 1'b0;
  end

  icache_line_fill_line_buf u_line_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (w_wr_en),
    .wr_idx_i  (beat_q),
    .wr_data_i (bus_rdata),
    .set_i     (w_set),
    .tag_i     (base_q),
    .clr_i     (w_clr),
    .cmp_tag_i (w_req_tag),
    .match_o   (w_buf_match),
    .tag_o     (w_buf_tag),
    .line_o    (resp_data)
  );

  assign bus_addr = line_word_addr(base_q, beat_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
      cool_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      done_q  <= done_d;
      cool_q  <= cool_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    done_d     = done_q;
    cool_d     = 1'b0;
    w_wr_en    = 1'b0;
    w_set      = 1'b0;
    w_clr      = buf_inv;
    bus_req    = 1'b0;
    fill_err   = 1'b0;
    resp_ready = 1'b0;

    case (state_q)
      IDLE: begin
        // The cache drops req_valid only in the cycle after resp_ready, so
        // the first IDLE cycle after RESP must ignore the still-high request.
        if (req_valid && !cool_q) begin
          // An invalidate arriving with a matching request forces a refetch.
          if (w_hit_ok && !buf_inv) begin
            state_d = RESP;
          end else begin
            base_d  = w_req_tag;
            beat_d  = '0;
            done_d  = 1'b0;
            w_clr   = 1'b1;
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        if (done_q) begin
          // Bus request is already low here; the line and tag are committed.
          done_d  = 1'b0;
          state_d = RESP;
        end else begin
          bus_req = 1'b1;
          if (bus_err) begin
            fill_err = 1'b1;
            w_clr    = 1'b1;
            beat_d   = '0;
            state_d  = IDLE;
          end else if (bus_ack) begin
            w_wr_en = 1'b1;
            beat_d  = beat_q + 1'b1;
            if (beat_q == IDX_W'(LINE_WORDS - 1)) begin
              w_set  = 1'b1;
              done_d = 1'b1;
            end
          end
        end
      end

      RESP: begin
        // Compare against the stored tag, not valid: a line invalidated on
        // its final beat is still returned once; a stale line is filtered.
        resp_ready = req_valid && (w_req_tag == w_buf_tag);
        cool_d     = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_line_fill.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_line_fill
// Purpose  : Self-checking bench for icache_line_fill: directed scenarios with
//            literal expectations plus a randomized phase, all compared every
//            cycle against a transaction-level model of the responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_icache_line_fill;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         resp_ready;
  logic [511:0] resp_data;
  logic         bus_req;
  logic [31:0]  bus_addr;
  logic         bus_ack;
  logic [31:0]  bus_rdata;
  logic         bus_err;
  logic         fill_err;
  logic         buf_inv;

  always #5 clk = ~clk;

  icache_line_fill dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err),
    .fill_err   (fill_err),
    .buf_inv    (buf_inv)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // ---------------- behavioural model ----------------
  // A fetch in flight is "m_got words received of line m_base"; 16 means
  // all words are in and the line is handed to the responder next cycle.
  bit          m_busy;
  int          m_got;
  logic [25:0] m_base;
  bit          m_resp;
  logic [25:0] m_resp_tag;
  bit          m_cool;
  bit          m_bvalid;
  logic [25:0] m_btag;
  logic [31:0] m_line [16];

  task automatic model_reset();
    m_busy = 0; m_got = 0; m_base = '0; m_resp = 0; m_resp_tag = '0;
    m_cool = 0; m_bvalid = 0; m_btag = '0;
  endtask

  function automatic logic [511:0] model_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = m_line[i];
    return v;
  endfunction

  // ---------------- bus responder ----------------
  int          bus_mode = 0;   // 0 zero-wait, 1 every 3rd cycle, 2 random
  int          wait_cnt = 0;
  int          err_beat = -1;
  logic [31:0] salt     = '0;

  task automatic bus_drive();
    bit fire;
    fire      = 0;
    bus_ack   = 0;
    bus_err   = 0;
    bus_rdata = bus_addr ^ salt;
    if (bus_req) begin
      case (bus_mode)
        0: fire = 1;
        1: begin fire = (wait_cnt == 2); wait_cnt = fire ? 0 : wait_cnt + 1; end
        default: fire = ($urandom_range(0, 9) < 6);
      endcase
      if (fire) begin
        if (err_beat >= 0 && int'(bus_addr[5:2]) == err_beat) begin
          bus_err  = 1;
          err_beat = -1;
        end else if (bus_mode == 2 && $urandom_range(0, 99) < 3) begin
          bus_err = 1;
        end else begin
          bus_ack = 1;
        end
      end
    end
  endtask

  // ---------------- per-scenario statistics ----------------
  int           cyc = 0;
  int           n_resp, n_ferr, n_ack, n_busreq, resp_cyc, cur_beat;
  bit           have_first, have_post_err, cur_resp;
  logic [31:0]  first_addr, last_addr, post_err_addr;
  logic [511:0] resp_line;

  task automatic clear_stats();
    n_resp = 0; n_ferr = 0; n_ack = 0; n_busreq = 0; resp_cyc = 0;
    have_first = 0; have_post_err = 0; first_addr = '0; last_addr = '0;
    post_err_addr = '0; resp_line = '0; cur_beat = -1; cur_resp = 0;
  endtask

  task automatic compare_outputs();
    bit exp_req, exp_rr;
    exp_req = m_busy && (m_got < 16);
    exp_rr  = m_resp && req_valid && (req_addr[31:6] == m_resp_tag);
    chk("bus_req", bus_req, exp_req);
    if (exp_req) chk("bus_addr", bus_addr, {m_base, 4'(m_got), 2'b00});
    chk("fill_err", fill_err, exp_req && bus_err);
    chk("resp_ready", resp_ready, exp_rr);
    if (exp_rr) chk("resp_data", resp_data, model_line());
  endtask

  task automatic collect();
    cur_resp = resp_ready;
    cur_beat = bus_req ? int'(bus_addr[5:2]) : -1;
    if (bus_req) begin
      n_busreq++;
      if (!have_first) begin have_first = 1; first_addr = bus_addr; end
      if (n_ferr > 0 && !have_post_err && !fill_err) begin
        have_post_err = 1; post_err_addr = bus_addr;
      end
      if (bus_ack && !bus_err) begin n_ack++; last_addr = bus_addr; end
    end
    if (fill_err) n_ferr++;
    if (resp_ready) begin n_resp++; resp_cyc = cyc; resp_line = resp_data; end
  endtask

  task automatic model_advance();
    if (m_resp) begin
      m_resp = 0;
      m_cool = 1;
    end else if (m_busy) begin
      if (m_got == 16) begin
        m_busy = 0; m_resp = 1; m_resp_tag = m_base;
      end else if (bus_err) begin
        m_busy = 0; m_bvalid = 0;
      end else if (bus_ack) begin
        m_line[m_got] = bus_rdata;
        m_got++;
        if (m_got == 16) begin m_btag = m_base; m_bvalid = 1; end
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (req_valid) begin
      if (m_bvalid && req_addr[31:6] == m_btag && !buf_inv) begin
        m_resp = 1; m_resp_tag = m_btag;
      end else begin
        m_busy = 1; m_base = req_addr[31:6]; m_got = 0; m_bvalid = 0;
      end
    end
    if (buf_inv) m_bvalid = 0;
  endtask

  // Called 1 time unit after a rising edge with the cycle's request inputs set.
  task automatic cycle();
    bus_drive();
    #1;
    compare_outputs();
    collect();
    model_advance();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_resp(input int budget, input string name);
    int k;
    k = 0;
    while (n_resp == 0 && k < budget) begin cycle(); k++; end
    if (n_resp == 0) timeout(name);
  endtask

  // Serve one request from scratch; the cache drops req_valid after the hit.
  task automatic serve(input logic [31:0] addr, input string name, output int lat);
    int t0;
    clear_stats();
    req_valid = 1; req_addr = addr;
    t0 = cyc;
    run_until_resp(400, name);
    lat = resp_cyc - t0;
    req_valid = 0;
    cycle();
  endtask

  int lat;

  initial begin
    rst_n = 0; req_valid = 0; req_addr = '0; buf_inv = 0;
    bus_ack = 0; bus_err = 0; bus_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus_req", bus_req, 1'b0);
    chk("reset_resp_ready", resp_ready, 1'b0);
    chk("reset_fill_err", fill_err, 1'b0);
    chk("reset_bus_addr", bus_addr, 32'h0);
    rst_n = 1;
    cycle();

    // Cold miss, zero-wait bus, word = address.
    bus_mode = 0;
    serve(32'h0000_1044, "cold_miss", lat);
    chk("cold_latency", 32'(lat), 32'd18);
    chk("cold_first_addr", first_addr, 32'h0000_1040);
    chk("cold_last_addr", last_addr, 32'h0000_107C);
    chk("cold_acks", 32'(n_ack), 32'd16);
    chk("cold_word0", resp_line[31:0], 32'h0000_1040);
    chk("cold_word15", resp_line[511:480], 32'h0000_107C);

    // Buffer hit on the same line.
    serve(32'h0000_1078, "buf_hit", lat);
    chk("hit_latency", 32'(lat), 32'd1);
    chk("hit_bus_cycles", 32'(n_busreq), 32'd0);
    chk("hit_word0", resp_line[31:0], 32'h0000_1040);
    chk("hit_word15", resp_line[511:480], 32'h0000_107C);

    // Wait states with an error on beat 7, then automatic refetch.
    bus_mode = 1; wait_cnt = 0; err_beat = 7;
    serve(32'h0000_3004, "err_refetch", lat);
    chk("err_pulses", 32'(n_ferr), 32'd1);
    chk("err_refetch_addr", post_err_addr, 32'h0000_3000);
    chk("err_acks", 32'(n_ack), 32'd23);
    chk("err_resp_count", 32'(n_resp), 32'd1);
    chk("err_word7", resp_line[255:224], 32'h0000_301C);

    // Address change at beat 5: stale line completes silently.
    bus_mode = 0;
    clear_stats();
    req_valid = 1; req_addr = 32'h0000_1044;
    begin
      int k;
      k = 0;
      while (cur_beat != 5 && k < 100) begin cycle(); k++; end
      if (cur_beat != 5) timeout("addr_change_beat5");
    end
    req_addr = 32'h0000_2000;
    run_until_resp(400, "addr_change");
    req_valid = 0;
    cycle();
    chk("chg_resp_count", 32'(n_resp), 32'd1);
    chk("chg_acks", 32'(n_ack), 32'd32);
    chk("chg_word0", resp_line[31:0], 32'h0000_2000);

    // Invalidate then re-request the same line: full refetch.
    buf_inv = 1;
    cycle();
    buf_inv = 0;
    serve(32'h0000_2010, "inv_refetch", lat);
    chk("inv_acks", 32'(n_ack), 32'd16);
    chk("inv_latency", 32'(lat), 32'd18);

    // Reset in the middle of a fetch.
    clear_stats();
    req_valid = 1; req_addr = 32'h0000_5000;
    begin
      int k;
      k = 0;
      while (cur_beat != 9 && k < 100) begin cycle(); k++; end
      if (cur_beat != 9) timeout("reset_beat9");
    end
    rst_n = 0;
    #1;
    chk("arst_bus_req", bus_req, 1'b0);
    chk("arst_resp_ready", resp_ready, 1'b0);
    chk("arst_bus_addr", bus_addr, 32'h0);
    model_reset();
    req_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    cycle();
    serve(32'h0000_5000, "post_reset", lat);
    chk("post_reset_acks", 32'(n_ack), 32'd16);

    // Randomized traffic.
    bus_mode = 2; salt = $urandom;
    clear_stats();
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] lines [5];
      lines[0] = 32'h0000_1000; lines[1] = 32'h0000_1040; lines[2] = 32'h0000_2000;
      lines[3] = 32'h0000_ABC0; lines[4] = $urandom & 32'hFFFF_FFC0;
      buf_inv = ($urandom_range(0, 99) < 2);
      if (cur_resp) begin
        req_valid = 0;
      end else if (!req_valid) begin
        if ($urandom_range(0, 9) < 3) begin
          req_valid = 1;
          req_addr  = lines[$urandom_range(0, 4)] | ($urandom & 32'h3F);
        end
      end else if ($urandom_range(0, 199) == 0) begin
        req_valid = 0;
      end else if ($urandom_range(0, 99) == 0) begin
        req_addr = lines[$urandom_range(0, 4)] | ($urandom & 32'h3F);
      end
      cycle();
    end
    buf_inv = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
